// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: default address width, queue entry layout, PC step.
package fetch_pkg;
  localparam int XLEN_DEF = 32;
  localparam int PC_INC   = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// In-order sync FIFO for fetched {pc, instr} entries; clear wins over push/pop.
// Head is visible combinationally; push and pop may happen in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DW    = XLEN_DEF + 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            push_dat_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (clear_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_q];
  assign count_o    = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding imem issue, redirect/discard; request-to-decode 2 cycles.
// Issue stalls when queued + in-flight reaches QDEPTH. FETCH_PERF_EN adds pop/redirect counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcsrce,
  input  logic [XLEN-1:0] pctargete,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            readyd,
  output logic            validd,
  output logic [31:0]     instrd,
  output logic [XLEN-1:0] pcd,
  output logic [XLEN-1:0] pcplus4d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushes
`endif
);
  localparam int              CW  = $clog2(QDEPTH) + 1;
  localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

  logic [XLEN-1:0] pcf_q, pcf_d, issued_pc_q, issued_pc_d;
  logic            inflight_q, inflight_d, discard_q, discard_d;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            issue, push, pop;
  logic [XLEN+31:0] head;

  // Counting the in-flight request reserves its slot, so a response never overflows.
  assign occ    = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign issue  = !rst && !pcsrce && (occ < (CW+1)'(QDEPTH));
  assign push   = imem_rvalid && inflight_q && !discard_q && !pcsrce;
  assign validd = (count != '0);
  assign pop    = validd && readyd && !pcsrce;

  fetch_queue #(.DW(XLEN + 32), .DEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (pcsrce),
    .push_i     (push),
    .push_dat_i ({issued_pc_q, imem_rdata}),
    .pop_i      (pop),
    .head_dat_o (head),
    .count_o    (count)
  );

  always_comb begin
    pcf_d       = pcf_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = inflight_q;
    discard_d   = discard_q;
    if (imem_rvalid) begin
      inflight_d = 1'b0;
      discard_d  = 1'b0;
    end
    // A response still outstanding at redirect belongs to the old path.
    if (pcsrce) begin
      pcf_d     = pctargete & ~XLEN'(3);
      discard_d = inflight_q && !imem_rvalid;
    end else if (issue) begin
      pcf_d       = pcf_q + INC;
      issued_pc_d = pcf_q;
      inflight_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcf_q       <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      pcf_q       <= pcf_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pcf_q;
  assign pcd       = validd ? head[XLEN+31:32] : '0;
  assign instrd    = validd ? head[31:0] : '0;
  assign pcplus4d  = validd ? head[XLEN+31:32] + INC : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_flushes_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (pop)    perf_fetched_q <= perf_fetched_q + 32'd1;
      if (pcsrce) perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`endif
endmodule
